// File: rtl/spi_pkg.sv
// Shared types, encodings and defaults for the SPI master core.
package spi_pkg;

   localparam int DW    = 32;
   localparam int DIV_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_XFER  = 3'd2,
      ST_HOLD  = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   localparam logic [1:0] LEN_8   = 2'b00;
   localparam logic [1:0] LEN_16  = 2'b01;
   localparam logic [1:0] LEN_32  = 2'b10;
   localparam logic [1:0] LEN_32B = 2'b11;

   // Frame length code to number of bits; both upper codes mean 32.
   function automatic logic [5:0] len_to_bits(input logic [1:0] len);
      logic [5:0] bits;
      case (len)
         LEN_8:   bits = 6'd8;
         LEN_16:  bits = 6'd16;
         LEN_32:  bits = 6'd32;
         LEN_32B: bits = 6'd32;
         default: bits = 6'd32;
      endcase
      return bits;
   endfunction

endpackage

// File: rtl/spi_master_core_if.sv
// Register-block side handshake of the SPI master core.
interface spi_master_core_if;
   import spi_pkg::*;

   logic             start_i;
   logic [DW-1:0]    tx_data_i;
   logic [1:0]       len_i;
   logic             cpol_i;
   logic             cpha_i;
   logic [DIV_W-1:0] div_i;
   logic             busy_o;
   logic             done_o;
   logic [DW-1:0]    rx_data_o;

   // Register block side: issues requests, observes status.
   modport master (
      output start_i, tx_data_i, len_i, cpol_i, cpha_i, div_i,
      input  busy_o, done_o, rx_data_o
   );

   // Shift engine side.
   modport slave (
      input  start_i, tx_data_i, len_i, cpol_i, cpha_i, div_i,
      output busy_o, done_o, rx_data_o
   );
endinterface

// File: rtl/spi_clkgen.sv
// Half-period timer and registered SCLK generator. tick_o marks every
// half-period boundary while enabled; lead/trail strobes fire only when
// toggling is allowed, in the cycle whose closing edge moves SCLK.
module spi_clkgen
   import spi_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             en_i,
   input  logic             tog_i,
   input  logic             clr_i,
   input  logic             cpol_i,
   input  logic [DIV_W-1:0] div_i,
   output logic             tick_o,
   output logic             lead_o,
   output logic             trail_o,
   output logic             sclk_o
);
   logic [DIV_W-1:0] cnt_q;
   logic             sclk_q;

   assign tick_o  = en_i & (cnt_q == div_i);
   assign lead_o  = tick_o & tog_i & (sclk_q == cpol_i);
   assign trail_o = tick_o & tog_i & (sclk_q != cpol_i);
   assign sclk_o  = sclk_q;

   // Count half-period cycles and toggle SCLK at each boundary.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q  <= {DIV_W{1'b0}};
         sclk_q <= 1'b0;
      end else if (clr_i) begin
         cnt_q  <= {DIV_W{1'b0}};
         sclk_q <= cpol_i;
      end else if (en_i) begin
         if (tick_o) begin
            cnt_q <= {DIV_W{1'b0}};
            if (tog_i) begin
               sclk_q <= ~sclk_q;
            end
         end else begin
            cnt_q <= cnt_q + {{(DIV_W-1){1'b0}}, 1'b1};
         end
      end
   end
endmodule

// File: rtl/spi_master_core.sv
// SPI shift engine: one CS-framed, MSB-first transfer per accepted start.
module spi_master_core
   import spi_pkg::*;
(
   input  logic             CLK_I,
   input  logic             RST_I,
   spi_master_core_if.slave bus_if,
   input  logic             miso_i,
   output logic             sclk_o,
   output logic             mosi_o,
   output logic             cs_n_o
);
   state_t           state_q;
   logic [DW-1:0]    tx_q;
   logic [DW-1:0]    rx_q;
   logic [DW-1:0]    rx_data_q;
   logic [5:0]       nbits_q;
   logic [5:0]       bit_cnt_q;
   logic             cpol_q;
   logic             cpha_q;
   logic [DIV_W-1:0] div_q;
   logic             mosi_q;
   logic             cs_n_q;
   logic             busy_q;
   logic             done_q;

   logic [5:0]       nbits_d;
   logic [DW-1:0]    tx_load_d;
   logic             cg_en, cg_tog, cg_clr, cg_cpol;
   logic             tick, lead, trail;

   // Left-align the frame so the MSB always sits at DW-1; bits at N and
   // above fall off the top.
   assign nbits_d   = len_to_bits(bus_if.len_i);
   assign tx_load_d = bus_if.tx_data_i << (6'(DW) - nbits_d);

   // Clock generator control per state; IDLE tracks the live polarity.
   always_comb begin
      cg_en   = 1'b0;
      cg_tog  = 1'b0;
      cg_clr  = 1'b0;
      cg_cpol = cpol_q;
      case (state_q)
         ST_IDLE: begin
            cg_clr  = 1'b1;
            cg_cpol = bus_if.cpol_i;
         end
         ST_SETUP: cg_en = 1'b1;
         ST_XFER: begin
            cg_en  = 1'b1;
            cg_tog = 1'b1;
         end
         ST_HOLD: cg_en  = 1'b1;
         ST_DONE: cg_clr = 1'b1;
         default: cg_clr = 1'b1;
      endcase
   end

   spi_clkgen u_clkgen (
      .clk_i   (CLK_I),
      .rst_ni  (RST_I),
      .en_i    (cg_en),
      .tog_i   (cg_tog),
      .clr_i   (cg_clr),
      .cpol_i  (cg_cpol),
      .div_i   (div_q),
      .tick_o  (tick),
      .lead_o  (lead),
      .trail_o (trail),
      .sclk_o  (sclk_o)
   );

   // Transfer state machine with shift registers and registered outputs.
   always_ff @(posedge CLK_I or negedge RST_I) begin
      if (!RST_I) begin
         state_q   <= ST_IDLE;
         tx_q      <= {DW{1'b0}};
         rx_q      <= {DW{1'b0}};
         rx_data_q <= {DW{1'b0}};
         nbits_q   <= 6'd0;
         bit_cnt_q <= 6'd0;
         cpol_q    <= 1'b0;
         cpha_q    <= 1'b0;
         div_q     <= {DIV_W{1'b0}};
         mosi_q    <= 1'b0;
         cs_n_q    <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               done_q <= 1'b0;
               if (bus_if.start_i) begin
                  tx_q      <= tx_load_d;
                  rx_q      <= {DW{1'b0}};
                  nbits_q   <= nbits_d;
                  bit_cnt_q <= 6'd0;
                  cpol_q    <= bus_if.cpol_i;
                  cpha_q    <= bus_if.cpha_i;
                  div_q     <= bus_if.div_i;
                  mosi_q    <= tx_load_d[DW-1];
                  cs_n_q    <= 1'b0;
                  busy_q    <= 1'b1;
                  state_q   <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               if (tick) begin
                  state_q <= ST_XFER;
               end
            end
            ST_XFER: begin
               if (lead) begin
                  if (cpha_q) begin
                     mosi_q <= tx_q[DW-1];
                  end else begin
                     rx_q <= {rx_q[DW-2:0], miso_i};
                  end
               end
               if (trail) begin
                  if (cpha_q) begin
                     rx_q <= {rx_q[DW-2:0], miso_i};
                  end else begin
                     mosi_q <= tx_q[DW-2];
                  end
                  tx_q <= {tx_q[DW-2:0], 1'b0};
                  if (bit_cnt_q == (nbits_q - 6'd1)) begin
                     bit_cnt_q <= 6'd0;
                     state_q   <= ST_HOLD;
                  end else begin
                     bit_cnt_q <= bit_cnt_q + 6'd1;
                  end
               end
            end
            ST_HOLD: begin
               if (tick) begin
                  cs_n_q    <= 1'b1;
                  busy_q    <= 1'b0;
                  done_q    <= 1'b1;
                  rx_data_q <= rx_q;
                  state_q   <= ST_DONE;
               end
            end
            ST_DONE: begin
               done_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               cs_n_q  <= 1'b1;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign mosi_o           = mosi_q;
   assign cs_n_o           = cs_n_q;
   assign bus_if.busy_o    = busy_q;
   assign bus_if.done_o    = done_q;
   assign bus_if.rx_data_o = rx_data_q;
endmodule

// File: tb/tb_spi_master_core.sv
// Directed bench for spi_master_core with a done-driven scoreboard.
module tb_spi_master_core;
   import spi_pkg::*;

   logic clk      = 1'b0;
   logic rst_n    = 1'b0;
   logic lb       = 1'b0;
   logic miso_fix = 1'b0;
   logic miso, sclk, mosi, cs_n;

   spi_master_core_if bus();

   spi_master_core dut (
      .CLK_I  (clk),
      .RST_I  (rst_n),
      .bus_if (bus),
      .miso_i (miso),
      .sclk_o (sclk),
      .mosi_o (mosi),
      .cs_n_o (cs_n)
   );

   assign miso = lb ? mosi : miso_fix;

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] rx;
      int          busy;
   } exp_t;

   exp_t        sb_q[$];
   int          checks   = 0;
   int          errors   = 0;
   int          done_cnt = 0;
   int          busy_cnt = 0;
   int          rise_cnt = 0;
   logic [31:0] mosi_cap = 32'd0;
   logic        sclk_prev = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: counts busy cycles and SCLK rises, checks each done pulse.
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         busy_cnt  = 0;
         sclk_prev = sclk;
      end else begin
         if (!cs_n && sclk && !sclk_prev) begin
            rise_cnt++;
            mosi_cap = {mosi_cap[30:0], mosi};
         end
         sclk_prev = sclk;
         if (bus.busy_o) busy_cnt++;
         if (bus.done_o) begin
            done_cnt++;
            if (sb_q.size() == 0) begin
               chk("done_without_expect", 32'(sb_q.size()), 32'd1);
            end else begin
               e = sb_q.pop_front();
               chk("rx_data", bus.rx_data_o, e.rx);
               chk("busy_len", 32'(busy_cnt), 32'(e.busy));
            end
            busy_cnt = 0;
         end
      end
   end

   task automatic start_xfer(input logic [31:0] tx, input logic [1:0] len,
                             input logic cpol, input logic cpha, input logic [7:0] div);
      @(negedge clk);
      bus.tx_data_i = tx;
      bus.len_i     = len;
      bus.cpol_i    = cpol;
      bus.cpha_i    = cpha;
      bus.div_i     = div;
      bus.start_i   = 1'b1;
      rise_cnt      = 0;
      mosi_cap      = 32'd0;
      @(negedge clk);
      bus.start_i   = 1'b0;
   endtask

   task automatic wait_done(output int lat);
      lat = 1;
      while (!bus.done_o && lat < 3000) begin
         @(negedge clk);
         lat++;
      end
      chk("done_seen", 32'(bus.done_o), 32'd1);
   endtask

   initial begin
      int lat;
      int dc0;
      bus.start_i   = 1'b0;
      bus.tx_data_i = 32'd0;
      bus.len_i     = 2'b00;
      bus.cpol_i    = 1'b0;
      bus.cpha_i    = 1'b0;
      bus.div_i     = 8'd0;

      // Reset values
      repeat (3) @(negedge clk);
      chk("rst_sclk", 32'(sclk), 32'd0);
      chk("rst_mosi", 32'(mosi), 32'd0);
      chk("rst_cs_n", 32'(cs_n), 32'd1);
      chk("rst_busy", 32'(bus.busy_o), 32'd0);
      chk("rst_done", 32'(bus.done_o), 32'd0);
      chk("rst_rx", bus.rx_data_o, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Loopback mode 0, len 8, div 0
      lb = 1'b1;
      sb_q.push_back('{32'h0000_00A5, 18});
      start_xfer(32'h0000_00A5, 2'b00, 1'b0, 1'b0, 8'd0);
      wait_done(lat);
      chk("m0_latency", 32'(lat), 32'd19);
      chk("m0_rises", 32'(rise_cnt), 32'd8);
      @(negedge clk);

      // Loopback mode 3, len 32, div 3
      bus.cpol_i = 1'b1;
      repeat (2) @(negedge clk);
      chk("m3_sclk_idle", 32'(sclk), 32'd1);
      sb_q.push_back('{32'hFEDC_1234, 264});
      start_xfer(32'hFEDC_1234, 2'b10, 1'b1, 1'b1, 8'd3);
      wait_done(lat);
      chk("m3_latency", 32'(lat), 32'd265);
      chk("m3_sclk_end", 32'(sclk), 32'd1);
      chk("m3_rises", 32'(rise_cnt), 32'd32);
      @(negedge clk);

      // Len 16, MISO held high, upper tx bits ignored
      lb       = 1'b0;
      miso_fix = 1'b1;
      sb_q.push_back('{32'h0000_FFFF, 68});
      start_xfer(32'hFFFF_8001, 2'b01, 1'b0, 1'b0, 8'd1);
      wait_done(lat);
      chk("l16_mosi", mosi_cap, 32'h0000_8001);
      chk("l16_rises", 32'(rise_cnt), 32'd16);
      chk("l16_latency", 32'(lat), 32'd69);
      @(negedge clk);

      // Starts mid-transfer and in DONE are ignored
      lb  = 1'b1;
      dc0 = done_cnt;
      sb_q.push_back('{32'h0000_003C, 18});
      start_xfer(32'h0000_003C, 2'b00, 1'b0, 1'b0, 8'd0);
      repeat (4) @(negedge clk);
      bus.tx_data_i = 32'h0000_00FF;
      bus.start_i   = 1'b1;
      @(negedge clk);
      bus.start_i   = 1'b0;
      wait_done(lat);
      chk("ign_latency", 32'(lat), 32'd14);
      bus.start_i = 1'b1;
      @(negedge clk);
      bus.start_i = 1'b0;
      chk("ign_busy", 32'(bus.busy_o), 32'd0);
      chk("ign_cs_n", 32'(cs_n), 32'd1);
      repeat (30) @(negedge clk);
      chk("ign_done_count", 32'(done_cnt - dc0), 32'd1);

      // Config changed while busy
      sb_q.push_back('{32'h0000_005A, 36});
      start_xfer(32'h0000_005A, 2'b00, 1'b0, 1'b0, 8'd1);
      repeat (2) @(negedge clk);
      bus.tx_data_i = 32'h0000_0000;
      bus.len_i     = 2'b10;
      bus.cpol_i    = 1'b1;
      bus.cpha_i    = 1'b1;
      bus.div_i     = 8'd0;
      wait_done(lat);
      chk("cfg_latency", 32'(lat), 32'd35);
      chk("cfg_rises", 32'(rise_cnt), 32'd8);
      @(negedge clk);

      // Asynchronous reset during XFER, mode 2
      start_xfer(32'h0000_0081, 2'b00, 1'b1, 1'b0, 8'd3);
      repeat (10) @(negedge clk);
      dc0 = done_cnt;
      #2 rst_n = 1'b0;
      #1;
      chk("arst_cs_n", 32'(cs_n), 32'd1);
      chk("arst_sclk", 32'(sclk), 32'd0);
      chk("arst_busy", 32'(bus.busy_o), 32'd0);
      chk("arst_mosi", 32'(mosi), 32'd0);
      chk("arst_rx", bus.rx_data_o, 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (300) @(negedge clk);
      chk("arst_no_done", 32'(done_cnt - dc0), 32'd0);
      chk("sb_empty", 32'(sb_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
